bp_be_stride_prefetch_gen: RTL and testbench

Prefetch request generator sitting directly downstream of the backend stride detector. It accepts start/confirm discovery events with a base address and signed stride, buffers them in a small command FIFO, and expands each into a sequence of line-aligned prefetch virtual addresses. It presents those addresses one at a time on a valid/yumi interface to the D$ prefetch port, with filtering of same-line duplicates and saturating drop accounting.

---
 rtl/bp_be_stride_prefetch_gen.sv | 88 ++++++++
 tb/tb_bp_be_stride_prefetch_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bp_be_stride_prefetch_gen.sv
// bp_be_stride_prefetch_gen: expands start/confirm stride-discovery events (base, stride) into line-aligned prefetch vaddrs on a valid/yumi port; flush_i clears queued and active work; idle_o and a saturating drop_count_o report status
module bp_be_stride_prefetch_gen #(
  parameter int vaddr_width_p = 39,
  parameter int stride_width_p = 8,
  parameter int block_offset_width_p = 6,
  parameter int fifo_els_p = 4,
  parameter int prefetch_degree_p = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_discovery_i,
  input  logic                      confirm_discovery_i,
  input  logic [vaddr_width_p-1:0]  base_addr_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic                      flush_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_vaddr_o,
  input  logic                      pf_yumi_i,
  output logic                      idle_o,
  output logic [7:0]                drop_count_o
);
  localparam int aw = $clog2(fifo_els_p);
  typedef struct packed {
    logic [vaddr_width_p-1:0] base;
    logic [vaddr_width_p-1:0] stride;
    logic [2:0]               deg;
  } cmd_s;
  typedef enum logic [1:0] {IDLE, LOAD, GEN} state_e;
  state_e state, state_n;
  cmd_s mem [fifo_els_p];
  cmd_s cur, cmd_in;
  logic [aw:0] wp, rp;
  logic [vaddr_width_p-1:0] addr_r, last_r, cand;
  logic [2:0] k_r;
  logic empty, full, enq_req, enq, drop, adv, pop;
  function automatic logic [vaddr_width_p-1:0] line(input logic [vaddr_width_p-1:0] a);
    return {a[vaddr_width_p-1:block_offset_width_p], {block_offset_width_p{1'b0}}};
  endfunction
  always_comb begin
    empty = wp == rp;
    full = (wp[aw] != rp[aw]) && (wp[aw-1:0] == rp[aw-1:0]);
    enq_req = (start_discovery_i || confirm_discovery_i) && stride_i != '0 && !flush_i;
    enq = enq_req && !full;
    drop = enq_req && full;
    cmd_in.base = base_addr_i;
    cmd_in.stride = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
    cmd_in.deg = confirm_discovery_i ? 3'(prefetch_degree_p) : 3'd1;
    cand = line(addr_r);
    pf_v_o = state == GEN && cand != last_r;
    pf_vaddr_o = pf_v_o ? cand : '0;
    adv = state == GEN && (cand == last_r || pf_yumi_i);
    pop = !flush_i && !empty && (state == IDLE || (adv && k_r == 3'd1));
    state_n = flush_i ? IDLE
            : pop ? LOAD
            : state == LOAD ? GEN
            : (adv && k_r == 3'd1) ? IDLE
            : state;
    idle_o = empty && state == IDLE && !pf_v_o;
  end
  always_ff @(posedge clk_i)
    if (enq) mem[wp[aw-1:0]] <= cmd_in;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cur <= '0;
      addr_r <= '0;
      last_r <= '0;
      k_r <= '0;
      drop_count_o <= '0;
    end else begin
      state <= state_n;
      wp <= wp + (aw+1)'(enq);
      rp <= flush_i ? wp : rp + (aw+1)'(pop);
      if (pop) cur <= mem[rp[aw-1:0]];
      if (state == LOAD) begin
        addr_r <= cur.base + cur.stride;
        last_r <= line(cur.base);
        k_r <= cur.deg;
      end else if (adv) begin
        addr_r <= addr_r + cur.stride;
        k_r <= k_r - 3'd1;
        if (pf_v_o) last_r <= cand;
      end
      if (drop && drop_count_o != 8'hff) drop_count_o <= drop_count_o + 8'd1;
    end
endmodule

// File: tb/tb_bp_be_stride_prefetch_gen.sv
// tb_bp_be_stride_prefetch_gen: directed and random checks of the stride prefetch generator against a slot-queue reference model
module tb_bp_be_stride_prefetch_gen;
  logic clk_i = 0;
  logic reset_n_i, start_discovery_i, confirm_discovery_i, flush_i, pf_yumi_i;
  logic [38:0] base_addr_i;
  logic [7:0] stride_i;
  logic pf_v_o, idle_o;
  logic [38:0] pf_vaddr_o;
  logic [7:0] drop_count_o;
  typedef struct {
    logic [38:0] base;
    logic [38:0] stride;
    int deg;
  } cmd_t;
  cmd_t mq[$];
  logic [39:0] sl[$];
  logic [38:0] got_q[$];
  int m_drop = 0;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk_i = ~clk_i;
  bp_be_stride_prefetch_gen dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .start_discovery_i(start_discovery_i), .confirm_discovery_i(confirm_discovery_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .flush_i(flush_i),
    .pf_v_o(pf_v_o), .pf_vaddr_o(pf_vaddr_o), .pf_yumi_i(pf_yumi_i),
    .idle_o(idle_o), .drop_count_o(drop_count_o)
  );
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [38:0] ln(logic [38:0] a);
    return a & ~39'h3f;
  endfunction
  task automatic expand(cmd_t c);
    logic [38:0] a = c.base + c.stride;
    logic [38:0] last = ln(c.base);
    sl.push_back(40'h0);
    for (int i = 0; i < c.deg; i++) begin
      if (ln(a) == last) sl.push_back(40'h0);
      else begin
        sl.push_back({1'b1, ln(a)});
        last = ln(a);
      end
      a = a + c.stride;
    end
  endtask
  task automatic cyc(bit st, bit cf, logic [38:0] b, logic [7:0] s, bit fl, bit y);
    bit ev, yy;
    int pre;
    cmd_t c;
    @(posedge clk_i);
    #1;
    ev = sl.size() > 0 && sl[0][39];
    chk("pf_v", pf_v_o, ev);
    if (ev) chk("pf_vaddr", pf_vaddr_o, sl[0][38:0]);
    chk("idle", idle_o, sl.size() == 0 && mq.size() == 0);
    chk("drop_count", drop_count_o, m_drop);
    yy = y && ev;
    start_discovery_i = st;
    confirm_discovery_i = cf;
    base_addr_i = b;
    stride_i = s;
    flush_i = fl;
    pf_yumi_i = yy;
    if (yy) got_q.push_back(sl[0][38:0]);
    if (fl) begin
      sl.delete();
      mq.delete();
      return;
    end
    pre = mq.size();
    if (sl.size() > 0 && (!sl[0][39] || yy)) void'(sl.pop_front());
    if (sl.size() == 0 && pre > 0) expand(mq.pop_front());
    if ((st || cf) && s != 0) begin
      if (pre >= 4) m_drop = m_drop < 255 ? m_drop + 1 : 255;
      else begin
        c.base = b;
        c.stride = {{31{s[7]}}, s};
        c.deg = cf ? 2 : 1;
        mq.push_back(c);
      end
    end
  endtask
  task automatic drain(int max);
    for (int i = 0; i < max && (sl.size() > 0 || mq.size() > 0); i++) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("drain_idle", idle_o, 1);
  endtask
  always @(negedge clk_i)
    if (reset_n_i && pf_yumi_i) chk("yumi_legal", pf_v_o, 1);
  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    reset_n_i = 0;
    {start_discovery_i, confirm_discovery_i, flush_i, pf_yumi_i} = '0;
    base_addr_i = '0;
    stride_i = '0;
    #12;
    chk("rst_pf_v", pf_v_o, 0);
    chk("rst_pf_vaddr", pf_vaddr_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_drop", drop_count_o, 0);
    @(negedge clk_i);
    reset_n_i = 1;
    got_q.delete();
    cyc(0, 1, 39'h1000, 8'd64, 0, 1);
    drain(20);
    chk("s1_count", got_q.size(), 2);
    chk("s1_a0", got_q[0], 39'h1040);
    chk("s1_a1", got_q[1], 39'h1080);
    got_q.delete();
    cyc(0, 1, 39'h2000, 8'h80, 0, 0);
    repeat (7) cyc(0, 0, 0, 0, 0, 0);
    chk("s2_hold_v", pf_v_o, 1);
    chk("s2_hold_addr", pf_vaddr_o, 39'h1f80);
    drain(20);
    chk("s2_a0", got_q[0], 39'h1f80);
    chk("s2_a1", got_q[1], 39'h1f00);
    got_q.delete();
    cyc(0, 1, 39'h3000, 8'd8, 0, 1);
    drain(20);
    chk("s3_none", got_q.size(), 0);
    got_q.delete();
    for (int i = 0; i < 6; i++) cyc(0, 1, 39'h10000 + 39'(i) * 39'h1000, 8'd64, 0, 0);
    cyc(0, 1, 39'h9000, 8'd0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("s4_drop", drop_count_o, 1);
    drain(100);
    chk("s4_count", got_q.size(), 10);
    chk("s4_drop_after", drop_count_o, 1);
    got_q.delete();
    cyc(1, 0, 39'h20000, 8'd64, 0, 1);
    drain(20);
    chk("s4_start_count", got_q.size(), 1);
    chk("s4_start_a0", got_q[0], 39'h20040);
    got_q.delete();
    cyc(0, 1, 39'h7f_ffff_ffc0, 8'd64, 0, 1);
    drain(20);
    chk("s5_wrap0", got_q[0], 39'h0);
    chk("s5_wrap1", got_q[1], 39'h40);
    cyc(0, 1, 39'h5000, 8'd64, 0, 0);
    cyc(0, 1, 39'h6000, 8'd64, 0, 0);
    cyc(0, 1, 39'h7000, 8'd64, 0, 0);
    cyc(0, 1, 39'h8000, 8'd64, 1, 1);
    got_q.delete();
    cyc(0, 0, 0, 0, 0, 1);
    chk("s6_flush_v", pf_v_o, 0);
    chk("s6_flush_idle", idle_o, 1);
    repeat (5) cyc(0, 0, 0, 0, 0, 1);
    chk("s6_nothing", got_q.size(), 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] s;
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0: s = 8'd64;
        1: s = 8'hc0;
        2: s = 8'd0;
        default: s = 8'($urandom_range(0, 255));
      endcase
      cyc(r < 10, r < 3 || (r >= 10 && r < 18), {$urandom(), $urandom()} >> 25, s,
          $urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0);
    end
    drain(200);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
